// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into single-cycle event
// pulses (press, click, long_press, repeat, release), a held level and a
// wrapping press counter. The repeat and release outputs are named
// repeat_pulse and release_pulse because the plain words are reserved
// keywords in SystemVerilog.
module button_event_gen #(
  parameter int LONG_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       press,
  output logic       click,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       release_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int HW = ($clog2(LONG_CYCLES) > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam int RW = ($clog2(REPEAT_CYCLES) > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, LONG} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [RW-1:0] rep_cnt, rep_cnt_n;
  logic [7:0]    press_count_n;
  logic          press_n, click_n, long_press_n, repeat_n, release_n, held_n;

  // Next-state, counter updates and next-cycle pulse values.
  always_comb begin
    state_n       = state;
    hold_cnt_n    = hold_cnt;
    rep_cnt_n     = rep_cnt;
    press_count_n = press_count;
    press_n       = 1'b0;
    click_n       = 1'b0;
    long_press_n  = 1'b0;
    repeat_n      = 1'b0;
    release_n     = 1'b0;
    case (state)
      LOCKOUT: begin
        // A level held through reset must drop before it can count.
        if (!btn_in) state_n = IDLE;
      end
      IDLE: begin
        if (btn_in) begin
          state_n       = PRESSED;
          press_n       = 1'b1;
          press_count_n = press_count + 8'd1;
          hold_cnt_n    = HW'(1);
        end
      end
      PRESSED: begin
        // Release takes priority over reaching the threshold.
        if (!btn_in) begin
          state_n   = IDLE;
          click_n   = 1'b1;
          release_n = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_n      = LONG;
          long_press_n = 1'b1;
          rep_cnt_n    = '0;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      LONG: begin
        if (!btn_in) begin
          state_n   = IDLE;
          release_n = 1'b1;
        end else if (rep_cnt == REP_LAST) begin
          repeat_n  = 1'b1;
          rep_cnt_n = '0;
        end else begin
          rep_cnt_n = rep_cnt + 1'b1;
        end
      end
      default: state_n = LOCKOUT;
    endcase
    held_n = (state_n == PRESSED) || (state_n == LONG);
  end

  // State, counters and registered outputs; reset drops any pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOCKOUT;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
      press_count   <= '0;
      press         <= 1'b0;
      click         <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_cnt_n;
      rep_cnt       <= rep_cnt_n;
      press_count   <= press_count_n;
      press         <= press_n;
      click         <= click_n;
      long_press    <= long_press_n;
      repeat_pulse  <= repeat_n;
      release_pulse <= release_n;
      held          <= held_n;
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen: hand-written vector table for reset and a
// short press, then a run-length reference model feeding a scoreboard queue
// for the long-hold, boundary, lockout, wrap and random sequences.
module tb_button_event_gen;

  localparam int L = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       press, click, long_press, repeat_pulse, release_pulse, held;
  logic [7:0] press_count;

  button_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .press(press), .click(click), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .release_pulse(release_pulse),
    .held(held), .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        b;
    logic [13:0] e;
  } vec_t;

  vec_t        vecs[8];
  logic [13:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state: lockout flag, run of high samples since press.
  logic        m_locked = 1'b1;
  int          m_run = 0;
  logic [7:0]  m_cnt = 8'd0;

  function automatic logic [13:0] pk(input logic p, c, lp, rp, rl, h,
                                     input logic [7:0] n);
    return {p, c, lp, rp, rl, h, n};
  endfunction

  task automatic model_step(input logic r, input logic b, output logic [13:0] e);
    logic p, c, lp, rp, rl, h;
    {p, c, lp, rp, rl, h} = 6'b0;
    if (r) begin
      m_locked = 1'b1;
      m_run    = 0;
      m_cnt    = 8'd0;
    end else if (m_locked) begin
      if (!b) m_locked = 1'b0;
    end else if (b) begin
      m_run = m_run + 1;
      if (m_run == 1) begin
        p     = 1'b1;
        m_cnt = m_cnt + 8'd1;
      end
      lp = (m_run == L);
      rp = (m_run > L) && (((m_run - L) % R) == 0);
      h  = 1'b1;
    end else if (m_run > 0) begin
      rl    = 1'b1;
      c     = (m_run < L);
      m_run = 0;
    end
    e = pk(p, c, lp, rp, rl, h, m_cnt);
  endtask

  task automatic step(input logic r, input logic b, input logic use_tab,
                      input logic [13:0] tab_e, input string name);
    logic [13:0] m, got, e;
    model_step(r, b, m);
    exp_q.push_back(use_tab ? tab_e : m);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    #1;
    got = {press, click, long_press, repeat_pulse, release_pulse, held, press_count};
    e   = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s vec %0d: got p/c/lp/rp/rl/h=%b cnt=%0d, required p/c/lp/rp/rl/h=%b cnt=%0d",
               name, vectors, got[13:8], got[7:0], e[13:8], e[7:0]);
    end
  endtask

  task automatic run(input logic b, input int n, input string name);
    for (int i = 0; i < n; i++) step(1'b0, b, 1'b0, 14'd0, name);
  endtask

  initial begin
    int seg;
    logic lvl;
    rst = 1'b1;
    btn_in = 1'b0;
    // Reset, IDLE entry, then a 3-sample short press.
    vecs[0] = '{1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0, 8'd0)};
    vecs[1] = '{1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0, 8'd0)};
    vecs[2] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 8'd0)};
    vecs[3] = '{1'b0, 1'b1, pk(1, 0, 0, 0, 0, 1, 8'd1)};
    vecs[4] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 8'd1)};
    vecs[5] = '{1'b0, 1'b1, pk(0, 0, 0, 0, 0, 1, 8'd1)};
    vecs[6] = '{1'b0, 1'b0, pk(0, 1, 0, 0, 1, 0, 8'd1)};
    vecs[7] = '{1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0, 8'd1)};
    for (int i = 0; i < 8; i++) step(vecs[i].r, vecs[i].b, 1'b1, vecs[i].e, "table");

    // Long hold with three repeats, release without click.
    run(1'b1, 20, "long_hold");
    run(1'b0, 2, "long_release");

    // Threshold boundary: 7 samples clicks, 8 samples long-presses.
    run(1'b1, 7, "hold7");
    run(1'b0, 2, "rel7");
    run(1'b1, 8, "hold8");
    run(1'b0, 2, "rel8");

    // One-cycle low gap between two presses.
    run(1'b1, 3, "gap_a");
    run(1'b0, 1, "gap_low");
    run(1'b1, 3, "gap_b");
    run(1'b0, 2, "gap_end");

    // Button held through reset is locked out until it drops.
    step(1'b1, 1'b1, 1'b0, 14'd0, "lock_rst");
    step(1'b1, 1'b1, 1'b0, 14'd0, "lock_rst");
    run(1'b1, 10, "lockout");
    run(1'b0, 1, "unlock");
    run(1'b1, 2, "first_press");
    run(1'b0, 2, "first_rel");

    // Reset during LONG: no release, everything clears.
    run(1'b1, 12, "to_long");
    step(1'b1, 1'b1, 1'b0, 14'd0, "rst_long");
    step(1'b0, 1'b0, 1'b0, 14'd0, "after_rst");
    run(1'b0, 1, "idle");

    // 256 short presses wrap the counter back to 0.
    for (int i = 0; i < 256; i++) begin
      run(1'b1, 1, "wrap_hi");
      run(1'b0, 1, "wrap_lo");
    end

    // Random hold/release segments.
    lvl = 1'b1;
    for (int i = 0; i < 40; i++) begin
      seg = $urandom_range(1, 14);
      run(lvl, seg, "random");
      lvl = ~lvl;
    end
    run(1'b0, 2, "final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Consumes the debounced level from the debouncer stage (one instance per button) and converts it into single-cycle event pulses.
- Events generated: press, click (short press and release), long-press, auto-repeat while held, and release.
- Also provides a held level and a wrapping press counter.
- Sits between the debouncer and the game/control FSM, which acts only on one-cycle pulses.

Parameters:
- LONG_CYCLES, 8: consecutive high samples, counting the first, needed to declare a long press. Must be >= 2.
- REPEAT_CYCLES, 4: period in cycles of repeat pulses once a long press has been declared. Must be >= 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  debounced button level from the debouncer (1 = pressed).
- press  output  1  one-cycle pulse on a recognised press.
- click  output  1  one-cycle pulse on release before the long-press threshold.
- long_press  output  1  one-cycle pulse when the long-press threshold is reached.
- repeat  output  1  one-cycle pulse every REPEAT_CYCLES cycles while long-held.
- release  output  1  one-cycle pulse on any release from a held state.
- held  output  1  level; 1 while the state is PRESSED or LONG.
- press_count  output  8  number of recognised presses, modulo 256.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset:
  - rst has priority over everything.
  - press, click, long_press, repeat, release and held are 0; press_count = 0; hold and repeat counters = 0.
  - State = LOCKOUT. Any pending pulse is dropped. Reset mid-hold produces no release or click.
- States are LOCKOUT, IDLE, PRESSED and LONG. Each edge describes the next state and the outputs for the following cycle. Pulse outputs default to 0 on every edge.
- LOCKOUT:
  - btn_in=0 -> IDLE, no outputs.
  - btn_in=1 -> stay. A button held through reset is never reported as a press.
- IDLE:
  - btn_in=1 -> PRESSED; press=1; press_count+1 (255 wraps to 0); hold_cnt=1.
  - btn_in=0 -> stay.
- PRESSED:
  - btn_in=0 -> IDLE; click=1; release=1.
  - btn_in=1 and hold_cnt==LONG_CYCLES-1 -> LONG; long_press=1; rep_cnt=0.
  - Otherwise hold_cnt+1.
  - long_press is asserted exactly LONG_CYCLES-1 cycles after press.
- LONG:
  - btn_in=0 -> IDLE; release=1; no click.
  - btn_in=1 and rep_cnt==REPEAT_CYCLES-1 -> repeat=1; rep_cnt=0.
  - Otherwise rep_cnt+1.
  - First repeat comes REPEAT_CYCLES cycles after long_press, then one every REPEAT_CYCLES cycles.
  - With REPEAT_CYCLES=1, repeat is 1 on every cycle after long_press while held.
- held:
  - Rises in the same cycle as press.
  - Falls in the same cycle release asserts.
  - Stays 1 through long_press and repeat.
- Latency: 1 cycle from sampling btn_in to the corresponding pulse.
- Counter widths: $clog2 of the parameter, minimum 1 bit. Counters never overflow, since they are compared before incrementing.
- Press/release transitions are mutually exclusive per edge. A 1-cycle low between highs yields release (+click if in PRESSED) then a new press on the next high sample, with press_count incremented.
- A release on the exact cycle the threshold would be hit: btn_in=0 wins, giving click, not long_press.
- Pulses are never asserted simultaneously, except click together with release.

Test Plan:
1. rst=1 for 2 cycles, btn_in=0, then release rst -> all outputs 0 during reset; one cycle later state IDLE, outputs still 0.
2. Short press: btn_in=1 for 3 cycles then 0 -> press one cycle after the first high sample; held=1 for 3 cycles; click=release=1 for one cycle; long_press never asserts; press_count=1.
3. Long hold: btn_in=1 for 20 cycles -> long_press exactly 7 cycles after press; repeat 4, 8 and 12 cycles after long_press; on release, release=1 and click=0.
4. Boundary: btn_in=1 for exactly 7 samples then 0 -> click, no long_press. Then 8 samples then 0 -> long_press on the 8th, release without click and with no repeat.
5. Held through reset: btn_in=1 across reset deassertion for 10 cycles -> no press or held. btn_in=0 then 1 -> press asserts normally; press_count=1.
6. Reset mid-hold in LONG -> all outputs 0 next cycle, no release pulse. Then 256 short presses -> press_count wraps to 0.
